alu_arbiter: RTL

- Shares the single 16-bit ALU between two independent requesters, for example the instruction-execute unit and an address-generation unit.
- Per transaction: arbitrates round-robin, latches the operands, drives the ALU enable/opcode/terms, waits for ALU done (with timeout), then returns the result and flags to the requester that won.
- Sits between the requesters and the ALU instance. It is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 14 +
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode map, flag bit positions
// and the arbiter state encoding.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_MUL = 6'd2;
  localparam logic [5:0] OP_DIV = 6'd3;
  localparam logic [5:0] OP_MOD = 6'd4;
  localparam logic [5:0] OP_AND = 6'd5;
  localparam logic [5:0] OP_OR  = 6'd6;
  localparam logic [5:0] OP_XOR = 6'd7;
  localparam logic [5:0] OP_NOT = 6'd8;
  localparam logic [5:0] OP_CMP = 6'd9;
  localparam logic [5:0] OP_MOV = 6'd10;
  localparam logic [5:0] OP_RSR = 6'd11;

  // Highest legal opcode (RSR); anything above is answered with an error.
  localparam int unsigned MAX_OPCODE = 11;

  localparam int FL_Z    = 0;
  localparam int FL_N    = 1;
  localparam int FL_C    = 2;
  localparam int FL_V    = 3;
  localparam int FLAGS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_any,
  output logic grant_idx
);

  assign grant_any = valid0 | valid1;
  // On a tie the requester that did not win last time goes next.
  assign grant_idx = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, operand latch,
// ALU handshake with timeout, and a one-cycle response to the winner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned OPC_W          = 6,
  parameter int unsigned MAX_OPCODE     = alu_pkg::MAX_OPCODE,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_b,

  input  logic              req0_valid,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,

  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,

  output logic              alu_enable,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_term1,
  output logic [DATA_W-1:0] alu_term2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  input  logic              alu_done
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAGS_W-1:0]  rsp_flags_q, rsp_flags_d;
  logic                rsp_err_q, rsp_err_d;
  logic                alu_enable_q, alu_enable_d;

  logic                arb_any, arb_idx;
  logic [OPC_W-1:0]    win_opc;
  logic [DATA_W-1:0]   win_a, win_b;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant_any  (arb_any),
    .grant_idx  (arb_idx)
  );

  assign win_opc = arb_idx ? req1_opcode : req0_opcode;
  assign win_a   = arb_idx ? req1_a      : req0_a;
  assign win_b   = arb_idx ? req1_b      : req0_b;

  // Acceptance is a same-cycle decode; gating with rst_b keeps it low while
  // the block is held in reset even if a requester is already valid.
  assign req0_ready = rst_b && (state_q == IDLE) && arb_any && !arb_idx;
  assign req1_ready = rst_b && (state_q == IDLE) && arb_any &&  arb_idx;
  assign rsp0_valid = (state_q == RESP) && !grant_q;
  assign rsp1_valid = (state_q == RESP) &&  grant_q;

  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign alu_enable = alu_enable_q;
  assign alu_opcode = opc_q;
  assign alu_term1  = a_q;
  assign alu_term2  = b_q;

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    opc_d        = opc_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          opc_d   = win_opc;
          a_d     = win_a;
          b_d     = win_b;
          cnt_d   = '0;
          if (win_opc > OPC_W'(MAX_OPCODE)) begin
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_err_d    = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A done arriving in the last allowed cycle still counts as success.
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_err_d    = 1'b0;
          cnt_d        = '0;
          state_d      = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_d = '0;
          rsp_flags_d  = '0;
          rsp_err_d    = 1'b1;
          cnt_d        = '0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    alu_enable_d = (state_d == BUSY);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      opc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      alu_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      opc_q        <= opc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      alu_enable_q <= alu_enable_d;
    end
  end

endmodule
